// File: rtl/sargantana_icache_pkg.sv
// Shared types and defaults for the icache array scheduler.
// Imported by the scheduler top and its flush walker.
package sargantana_icache_pkg;

  localparam int unsigned ICACHE_IDX_WIDTH = 6;
  localparam int unsigned STARVE_LIM_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } sched_state_t;

endpackage

// File: rtl/sargantana_icache_flush_walker.sv
// Set-index walker for the full-cache flush.
// Counts 0..2**IDX_WIDTH-1 and pulses done the cycle after the last set.
module sargantana_icache_flush_walker
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned IDX_WIDTH = ICACHE_IDX_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 run_i,
  output logic [IDX_WIDTH-1:0] idx_o,
  output logic                 last_o,
  output logic                 done_o
);

  logic [IDX_WIDTH-1:0] cnt_q;
  logic                 done_q;

  assign last_o = run_i && (cnt_q == {IDX_WIDTH{1'b1}});
  assign idx_o  = cnt_q;
  assign done_o = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_o;
      // Wrap is explicit at the terminal set, never by overflow.
      if (start_i || last_o)
        cnt_q <= '0;
      else if (run_i)
        cnt_q <= cnt_q + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/sargantana_icache_array_sched.sv
// Single-port grant scheduler for the icache arrays.
// Flush walk, then aged inval, refill, inval, core read.
module sargantana_icache_array_sched
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned IDX_WIDTH  = ICACHE_IDX_WIDTH,
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_req_i,
  input  logic                 refill_valid_i,
  input  logic [IDX_WIDTH-1:0] refill_idx_i,
  output logic                 refill_ready_o,
  input  logic                 inval_valid_i,
  input  logic [IDX_WIDTH-1:0] inval_idx_i,
  output logic                 inval_ready_o,
  input  logic                 core_req_i,
  input  logic [IDX_WIDTH-1:0] core_idx_i,
  output logic                 core_gnt_o,
  output logic                 cache_rd_ena_o,
  output logic                 cache_wr_ena_o,
  output logic                 inval_o,
  output logic                 flush_ena_o,
  output logic [IDX_WIDTH-1:0] cline_index_o,
  output logic                 flush_done_o,
  output logic                 busy_o
);

  localparam int unsigned AW = $clog2(STARVE_LIM + 1);

  sched_state_t state_q, state_d;
  logic [AW-1:0] age_q;
  logic aged;
  logic sel_inv, sel_ref, sel_core;
  logic [IDX_WIDTH-1:0] walk_idx;
  logic walk_last;
  logic walk_start;
  logic walk_run;

  assign walk_run   = (state_q == FLUSH);
  assign walk_start = (state_q == IDLE) && flush_req_i;
  assign busy_o     = walk_run;
  assign aged       = (age_q == AW'(STARVE_LIM));

  assign sel_inv  = inval_valid_i && (aged || !refill_valid_i);
  assign sel_ref  = refill_valid_i && !sel_inv;
  assign sel_core = core_req_i && !inval_valid_i
                 && !refill_valid_i;

  sargantana_icache_flush_walker #(
    .IDX_WIDTH(IDX_WIDTH)
  ) u_walker (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(walk_start),
    .run_i  (walk_run),
    .idx_o  (walk_idx),
    .last_o (walk_last),
    .done_o (flush_done_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      if (!inval_valid_i || inval_ready_o)
        age_q <= '0;
      else if (!aged)
        age_q <= age_q + AW'(1);
    end
  end

  always_comb begin
    state_d        = state_q;
    refill_ready_o = 1'b0;
    inval_ready_o  = 1'b0;
    core_gnt_o     = 1'b0;
    cache_rd_ena_o = 1'b0;
    cache_wr_ena_o = 1'b0;
    inval_o        = 1'b0;
    flush_ena_o    = 1'b0;
    cline_index_o  = core_idx_i;
    unique case (state_q)
      IDLE: begin
        if (flush_req_i)
          state_d = FLUSH;
        unique case (1'b1)
          sel_inv: begin
            inval_ready_o = 1'b1;
            inval_o       = 1'b1;
            cline_index_o = inval_idx_i;
          end
          sel_ref: begin
            refill_ready_o = 1'b1;
            cache_wr_ena_o = 1'b1;
            cline_index_o  = refill_idx_i;
          end
          sel_core: begin
            core_gnt_o     = 1'b1;
            cache_rd_ena_o = 1'b1;
          end
          default: ;
        endcase
      end
      FLUSH: begin
        // Pending invalidations are absorbed: the walk clears every set.
        flush_ena_o   = 1'b1;
        inval_ready_o = 1'b1;
        cline_index_o = walk_idx;
        if (walk_last)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sargantana_icache_array_sched.sv
// Randomized check of the icache array scheduler.
// A cycle-level behavioural model predicts every output.
module tb_sargantana_icache_array_sched;

  localparam int IW  = 6;
  localparam int LIM = 8;
  localparam int NSETS = 1 << IW;

  logic clk = 1'b0;
  logic rst;
  logic flush_req;
  logic refill_valid;
  logic [IW-1:0] refill_idx;
  logic refill_ready;
  logic inval_valid;
  logic [IW-1:0] inval_idx;
  logic inval_ready;
  logic core_req;
  logic [IW-1:0] core_idx;
  logic core_gnt;
  logic rd_ena, wr_ena, inval, flush_ena;
  logic [IW-1:0] cline_index;
  logic flush_done, busy;

  int n_vec = 0;
  int n_bad = 0;

  // model state
  bit m_fl = 0;
  int m_pos = 0;
  int m_age = 0;
  bit m_done = 0;
  int fl_run = 0;

  always #5 clk = ~clk;

  sargantana_icache_array_sched #(
    .IDX_WIDTH(IW),
    .STARVE_LIM(LIM)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_req_i   (flush_req),
    .refill_valid_i(refill_valid),
    .refill_idx_i  (refill_idx),
    .refill_ready_o(refill_ready),
    .inval_valid_i (inval_valid),
    .inval_idx_i   (inval_idx),
    .inval_ready_o (inval_ready),
    .core_req_i    (core_req),
    .core_idx_i    (core_idx),
    .core_gnt_o    (core_gnt),
    .cache_rd_ena_o(rd_ena),
    .cache_wr_ena_o(wr_ena),
    .inval_o       (inval),
    .flush_ena_o   (flush_ena),
    .cline_index_o (cline_index),
    .flush_done_o  (flush_done),
    .busy_o        (busy)
  );

  task automatic chk(input string tag,
                     input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d @%0t",
               tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check outputs, advance the model.
  task automatic step(input bit r, input bit fr,
                      input bit rv, input int ri,
                      input bit iv, input int ii,
                      input bit cr, input int ci);
    int e_rr, e_ir, e_cg, e_rd, e_wr, e_in, e_fe, e_ix;
    rst = r; flush_req = fr;
    refill_valid = rv; refill_idx = IW'(ri);
    inval_valid = iv; inval_idx = IW'(ii);
    core_req = cr; core_idx = IW'(ci);
    #3;
    e_rr = 0; e_ir = 0; e_cg = 0; e_rd = 0;
    e_wr = 0; e_in = 0; e_fe = 0; e_ix = ci;
    if (m_fl) begin
      e_fe = 1; e_ir = 1; e_ix = m_pos;
    end else if (iv && m_age >= LIM) begin
      e_ir = 1; e_in = 1; e_ix = ii;
    end else if (rv) begin
      e_rr = 1; e_wr = 1; e_ix = ri;
    end else if (iv) begin
      e_ir = 1; e_in = 1; e_ix = ii;
    end else if (cr) begin
      e_cg = 1; e_rd = 1;
    end
    chk("refill_ready", int'(refill_ready), e_rr);
    chk("inval_ready", int'(inval_ready), e_ir);
    chk("core_gnt", int'(core_gnt), e_cg);
    chk("rd_ena", int'(rd_ena), e_rd);
    chk("wr_ena", int'(wr_ena), e_wr);
    chk("inval", int'(inval), e_in);
    chk("flush_ena", int'(flush_ena), e_fe);
    chk("cline_index", int'(cline_index), e_ix);
    chk("flush_done", int'(flush_done), int'(m_done));
    chk("busy", int'(busy), int'(m_fl));
    if (flush_ena) fl_run++;
    if (r) begin
      m_fl = 0; m_pos = 0; m_age = 0; m_done = 0;
    end else begin
      m_done = m_fl && m_pos == NSETS - 1;
      if (!iv || e_ir) m_age = 0;
      else if (m_age < LIM) m_age++;
      if (m_fl) begin
        if (m_pos == NSETS - 1) m_fl = 0;
        else m_pos++;
      end else if (fr) begin
        m_fl = 1; m_pos = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle_step();
    // core lookup, then refill beats core
    step(0, 0, 0, 0, 0, 0, 1, 5);
    step(0, 0, 1, 3, 0, 0, 1, 9);
    // starvation: granted on the 9th cycle
    for (int i = 0; i < 10; i++) begin
      if (i == 8) chk("starve_9th", int'(inval_ready), 1);
      step(0, 0, 1, i, 1, 7, 0, 0);
    end
    idle_step();
    // full flush walk with refill/inval pressure
    fl_run = 0;
    step(0, 1, 0, 0, 0, 0, 1, 2);
    for (int i = 0; i < NSETS; i++)
      step(0, 0, 1, 11, i % 3 == 0, 4, 1, 1);
    chk("flush_len", fl_run, NSETS);
    step(0, 0, 1, 11, 0, 0, 0, 0);
    idle_step();
    // reset at flush index 20, then restart
    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) idle_step();
    chk("idx_at_rst", int'(cline_index), 20);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle_step();
    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle_step();
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 3) != 0,
           int'($urandom_range(0, NSETS - 1)),
           $urandom_range(0, 2) == 0,
           int'($urandom_range(0, NSETS - 1)),
           $urandom_range(0, 1) == 0,
           int'($urandom_range(0, NSETS - 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
